// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write signals shared by the LEGv8 loader and the encoder.
interface instr_encoder_if #(parameter int AW = 6) ();
   logic          in_valid;
   logic          in_ready;
   logic          in_last;
   logic [3:0]    op;
   logic [4:0]    rd;
   logic [4:0]    rn;
   logic [4:0]    rm;
   logic [25:0]   imm;
   logic [1:0]    hw;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;

   modport slave (
      input  in_valid, in_last, op, rd, rn, rm, imm, hw,
      output in_ready, wr_en, wr_addr, wr_data
   );

   modport master (
      output in_valid, in_last, op, rd, rn, rm, imm, hw,
      input  in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic LEGv8 requests (11-instruction subset) into 32-bit words and
// writes them sequentially into instruction memory, one word per cycle.
//
// state | meaning
// IDLE  | no session; requests ignored, in_ready low
// RUN   | session open; accepting requests while count < DEPTH
// FULL  | DEPTH words written without in_last; waits for start or reset
module instr_encoder #(
   parameter int AW    = 6,
   parameter int DEPTH = 64
) (
   input  logic          CLK,
   input  logic          resetl,
   input  logic          start,
   instr_encoder_if.slave bus,
   output logic [AW:0]   count,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_C   = (AW+1)'(1);

   state_t        state, state_nxt;
   logic [AW:0]   count_nxt, count_base;
   logic [AW-1:0] addr_q, addr_nxt;
   logic [31:0]   data_q, data_nxt, enc;
   logic          wr_en_q, wr_en_nxt, done_nxt, err_nxt;
   logic          legal, accept;
   logic [25:0]   imm;

   assign imm         = bus.imm;
   assign bus.in_ready = (state == RUN) && (count < DEPTH_C);
   assign accept      = bus.in_valid & bus.in_ready;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = addr_q;
   assign bus.wr_data = data_q;

   always_comb begin
      enc   = '0;
      legal = 1'b1;
      case (bus.op)
         4'd0:  enc = {11'b10001010000, bus.rm, 6'b000000, bus.rn, bus.rd};
         4'd1:  enc = {11'b10101010000, bus.rm, 6'b000000, bus.rn, bus.rd};
         4'd2:  enc = {11'b10001011000, bus.rm, 6'b000000, bus.rn, bus.rd};
         4'd3:  enc = {11'b11001011000, bus.rm, 6'b000000, bus.rn, bus.rd};
         4'd4: begin
            enc   = {10'b1001000100, imm[11:0], bus.rn, bus.rd};
            legal = (imm[25:12] == '0);
         end
         4'd5: begin
            enc   = {10'b1101000100, imm[11:0], bus.rn, bus.rd};
            legal = (imm[25:12] == '0);
         end
         4'd6: begin
            enc   = {9'b110100101, bus.hw, imm[15:0], bus.rd};
            legal = (imm[25:16] == '0);
         end
         4'd7:  enc = {6'b000101, imm};
         // Signed offsets must sign-extend cleanly from their field width
         4'd8: begin
            enc   = {8'b10110100, imm[18:0], bus.rd};
            legal = (&imm[25:18]) | ~(|imm[25:18]);
         end
         4'd9: begin
            enc   = {11'b11111000010, imm[8:0], 2'b00, bus.rn, bus.rd};
            legal = (&imm[25:8]) | ~(|imm[25:8]);
         end
         4'd10: begin
            enc   = {11'b11111000000, imm[8:0], 2'b00, bus.rn, bus.rd};
            legal = (&imm[25:8]) | ~(|imm[25:8]);
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      addr_nxt   = addr_q;
      data_nxt   = data_q;
      wr_en_nxt  = 1'b0;
      done_nxt   = 1'b0;
      err_nxt    = err;
      count_base = start ? '0 : count;
      if (start) begin
         state_nxt = RUN;
         count_nxt = '0;
         err_nxt   = 1'b0;
      end
      // A beat accepted alongside a restart becomes word 0 of the new session
      if (accept) begin
         if (legal) begin
            wr_en_nxt = 1'b1;
            addr_nxt  = count_base[AW-1:0];
            data_nxt  = enc;
            count_nxt = count_base + ONE_C;
            if (!bus.in_last && (count_base + ONE_C == DEPTH_C))
               state_nxt = FULL;
         end else begin
            err_nxt = 1'b1;
         end
         if (bus.in_last) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!resetl) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge CLK) begin
      if (!resetl) begin
         count   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_en_q <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         count   <= count_nxt;
         addr_q  <= addr_nxt;
         data_q  <= data_nxt;
         wr_en_q <= wr_en_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-encoded LEGv8 words, DEPTH shrunk to 4.
module tb_instr_encoder;
   localparam int AW = 6;

   logic        CLK = 1'b0;
   logic        resetl;
   logic        start;
   logic [AW:0] count;
   logic        done;
   logic        err;
   int          checks = 0;
   int          errors = 0;

   instr_encoder_if #(.AW(AW)) bus ();

   instr_encoder #(.AW(AW), .DEPTH(4)) dut (
      .CLK(CLK), .resetl(resetl), .start(start), .bus(bus),
      .count(count), .done(done), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [25:0] imm, input logic [1:0] hw,
                      input logic last);
      bus.in_valid = 1'b1;
      bus.op = op; bus.rd = rd; bus.rn = rn; bus.rm = rm;
      bus.imm = imm; bus.hw = hw; bus.in_last = last;
   endtask

   task automatic chk_wr(input string tag, input logic [AW-1:0] addr, input logic [31:0] data);
      chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd1);
      chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'(addr));
      chk({tag, "_wr_data"}, bus.wr_data, data);
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      resetl = 1'b0; start = 1'b0;
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.op = '0; bus.rd = '0;
      bus.rn = '0; bus.rm = '0; bus.imm = '0; bus.hw = '0;
      step(); step();
      chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      resetl = 1'b1;

      // ADD X3, X1, X2
      do_start();
      chk("run_in_ready", 32'(bus.in_ready), 32'd1);
      req(4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b0);
      step();
      bus.in_valid = 1'b0;
      chk_wr("add", 6'd0, 32'h8B020023);
      chk("add_count", 32'(count), 32'd1);
      step();
      chk("add_wr_idle", 32'(bus.wr_en), 32'd0);

      // LDUR then B with in_last, back to back
      do_start();
      req(4'd9, 5'd9, 5'd22, 5'd0, 26'd64, 2'd0, 1'b0);
      step();
      chk_wr("ldur", 6'd0, 32'hF84402C9);
      req(4'd7, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 2'd0, 1'b1);
      step();
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      chk_wr("b", 6'd1, 32'h17FFFFFF);
      chk("b_done", 32'(done), 32'd1);
      chk("b_in_ready", 32'(bus.in_ready), 32'd0);
      chk("b_count", 32'(count), 32'd2);
      step();
      chk("b_done_once", 32'(done), 32'd0);
      req(4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b0);
      step();
      bus.in_valid = 1'b0;
      chk("idle_ignore_wr", 32'(bus.wr_en), 32'd0);
      chk("idle_ignore_count", 32'(count), 32'd2);

      // MOVZ then rejected requests
      do_start();
      req(4'd6, 5'd0, 5'd0, 5'd0, 26'h000BEEF, 2'd1, 1'b0);
      step();
      chk_wr("movz", 6'd0, 32'hD2B7DDE0);
      req(4'd12, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 1'b0);
      step();
      chk("ill_wr_en", 32'(bus.wr_en), 32'd0);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_count", 32'(count), 32'd1);
      req(4'd8, 5'd0, 5'd0, 5'd0, 26'h0040000, 2'd0, 1'b0);
      step();
      chk("cbz_rej_wr_en", 32'(bus.wr_en), 32'd0);
      chk("cbz_rej_err", 32'(err), 32'd1);
      req(4'd4, 5'd1, 5'd2, 5'd0, 26'h0001000, 2'd0, 1'b0);
      step();
      chk("addi_rej_wr_en", 32'(bus.wr_en), 32'd0);
      req(4'd9, 5'd1, 5'd2, 5'd0, 26'd256, 2'd0, 1'b0);
      step();
      bus.in_valid = 1'b0;
      chk("ldur_rej_wr_en", 32'(bus.wr_en), 32'd0);
      chk("rej_count", 32'(count), 32'd1);

      // Fill DEPTH=4 without in_last, then a held fifth request
      do_start();
      chk("restart_count", 32'(count), 32'd0);
      chk("restart_err", 32'(err), 32'd0);
      req(4'd4, 5'd1, 5'd2, 5'd0, 26'h0000FFF, 2'd0, 1'b0);
      step();
      chk_wr("addi", 6'd0, 32'h913FFC41);
      req(4'd8, 5'd5, 5'd0, 5'd0, 26'h3FFFFFC, 2'd0, 1'b0);
      step();
      chk_wr("cbz", 6'd1, 32'hB4FFFF85);
      req(4'd10, 5'd1, 5'd31, 5'd0, 26'h3FFFFFF, 2'd0, 1'b0);
      step();
      chk_wr("stur", 6'd2, 32'hF81FF3E1);
      req(4'd3, 5'd31, 5'd31, 5'd31, 26'd0, 2'd0, 1'b0);
      step();
      chk_wr("sub", 6'd3, 32'hCB1F03FF);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      chk("full_count", 32'(count), 32'd4);
      req(4'd1, 5'd4, 5'd5, 5'd6, 26'd0, 2'd0, 1'b0);
      step();
      chk("full_held_wr_en", 32'(bus.wr_en), 32'd0);
      chk("full_held_count", 32'(count), 32'd4);
      chk("full_held_done", 32'(done), 32'd0);
      do_start();
      chk("full_restart_count", 32'(count), 32'd0);
      chk("full_restart_ready", 32'(bus.in_ready), 32'd1);
      chk("full_restart_wr_en", 32'(bus.wr_en), 32'd0);
      step();
      bus.in_valid = 1'b0;
      // ORR X4, X5, X6
      chk_wr("orr", 6'd0, 32'hAA0600A4);

      // in_last on the DEPTH-th word ends the session rather than filling
      req(4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 1'b0);
      step();
      chk_wr("and1", 6'd1, 32'h8A000000);
      step();
      chk_wr("and2", 6'd2, 32'h8A000000);
      bus.in_last = 1'b1;
      step();
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      chk_wr("and3", 6'd3, 32'h8A000000);
      chk("last_full_done", 32'(done), 32'd1);
      chk("last_full_count", 32'(count), 32'd4);
      step();
      chk("last_full_done_off", 32'(done), 32'd0);

      // Reset the cycle after an accept
      do_start();
      req(4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b0);
      step();
      bus.in_valid = 1'b0;
      chk("pre_rst_wr_en", 32'(bus.wr_en), 32'd1);
      resetl = 1'b0;
      step();
      chk("rst2_wr_en", 32'(bus.wr_en), 32'd0);
      chk("rst2_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("rst2_wr_data", bus.wr_data, 32'd0);
      chk("rst2_count", 32'(count), 32'd0);
      chk("rst2_in_ready", 32'(bus.in_ready), 32'd0);
      resetl = 1'b1;

      // Reset coinciding with the accept edge discards the write
      do_start();
      req(4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b0);
      resetl = 1'b0;
      step();
      bus.in_valid = 1'b0;
      chk("rst3_wr_en", 32'(bus.wr_en), 32'd0);
      chk("rst3_count", 32'(count), 32'd0);
      resetl = 1'b1;
      step();
      chk("rst3_idle_ready", 32'(bus.in_ready), 32'd0);

      // start while a write is pending
      do_start();
      req(4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b0);
      step();
      step();
      bus.in_valid = 1'b0;
      chk_wr("pend", 6'd1, 32'h8B020023);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("pend_restart_count", 32'(count), 32'd0);
      chk("pend_restart_wr_en", 32'(bus.wr_en), 32'd0);
      req(4'd3, 5'd31, 5'd31, 5'd31, 26'd0, 2'd0, 1'b0);
      step();
      bus.in_valid = 1'b0;
      chk_wr("pend_next", 6'd0, 32'hCB1F03FF);
      chk("pend_next_count", 32'(count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
